// File: rtl/calc_alu_responder_pkg.sv
// Shared definitions for the calculator datapath: opcodes, FSM encodings,
// widths and the operator-priority helper also used by the keypad parser.
package calc_pkg;

  localparam int W         = 16;
  localparam int MUL_DIGIT = 4;

  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;
  localparam logic [3:0] OP_MOD = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Higher value binds tighter when the parser reduces an expression.
  function automatic logic [1:0] op_priority(input logic [3:0] op);
    case (op)
      OP_MOD:          op_priority = 2'd3;
      OP_MUL, OP_DIV:  op_priority = 2'd2;
      default:         op_priority = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/calc_alu_responder_divider.sv
// Restoring divider, one quotient bit per cycle MSB first; a zero divisor
// is flagged and reported as done on the cycle right after start.
module calc_seq_divider #(
  parameter int W = 16
) (
  input  logic         IN_clk,
  input  logic         IN_reset,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         done_o,
  output logic         dbz_o,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o
);

  localparam int CW = $clog2(W);

  logic          busy_q, busy_d;
  logic          dbz_q, dbz_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  div_q, div_d;

  logic [W:0]    shifted;
  logic [W:0]    diff;
  logic [W-1:0]  quo_step;
  logic [W-1:0]  rem_step;

  always_comb begin
    shifted  = {rem_q, quo_q[W-1]};
    diff     = shifted - {1'b0, div_q};
    quo_step = {quo_q[W-2:0], ~diff[W]};
    rem_step = diff[W] ? shifted[W-1:0] : diff[W-1:0];
  end

  always_comb begin
    busy_d = busy_q;
    dbz_d  = 1'b0;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    div_d  = div_q;
    if (start_i) begin
      quo_d  = dividend_i;
      rem_d  = '0;
      div_d  = divisor_i;
      cnt_d  = '0;
      busy_d = (divisor_i != '0);
      dbz_d  = (divisor_i == '0);
    end else if (busy_q) begin
      quo_d = quo_step;
      rem_d = rem_step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(W - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge IN_clk or negedge IN_reset) begin
    if (!IN_reset) begin
      busy_q <= 1'b0;
      dbz_q  <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
    end else begin
      busy_q <= busy_d;
      dbz_q  <= dbz_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
    end
  end

  // Results are the values the final iteration is about to store, so the
  // caller can register them on the same edge the divider finishes.
  assign done_o      = (busy_q && cnt_q == CW'(W - 1)) || dbz_q;
  assign dbz_o       = dbz_q;
  assign quotient_o  = quo_step;
  assign remainder_o = rem_step;

endmodule

// File: rtl/calc_alu_responder.sv
// Arithmetic responder: starts on a rising IN_finish, runs add/sub/mul/div/mod
// over one or more cycles and pulses OUT_done with the registered answer.
import calc_pkg::*;

module calc_alu_responder #(
  parameter int W         = calc_pkg::W,
  parameter int MUL_DIGIT = calc_pkg::MUL_DIGIT
) (
  input  logic         IN_clk,
  input  logic         IN_reset,
  input  logic [7:0]   IN_SRCH,
  input  logic [7:0]   IN_SRCL,
  input  logic [7:0]   IN_DSTH,
  input  logic [7:0]   IN_DSTL,
  input  logic [3:0]   IN_ALU_OP,
  input  logic         IN_finish,
  output logic [W-1:0] OUT_ans,
  output logic         OUT_done,
  output logic         OUT_busy,
  output logic         OUT_err,
  output logic         OUT_ovf,
  output logic [1:0]   OUT_state
);

  localparam int NDIG = W / MUL_DIGIT;
  localparam int CW   = $clog2(NDIG);

  state_t         state_q, state_d;
  logic           hist_q, hist_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [3:0]     op_q, op_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   ans_q, ans_d;
  logic           err_q, err_d, ovf_q, ovf_d, done_q, done_d, busy_q, busy_d;

  logic           start;
  logic           div_done, div_dbz;
  logic [W-1:0]   div_quo, div_rem;
  logic [W:0]     sum;
  logic [MUL_DIGIT-1:0] digit;
  logic [2*W-1:0] prod_next;
  logic           fin, fin_err, fin_ovf;
  logic [W-1:0]   fin_ans;

  assign start = (state_q == ST_IDLE) && IN_finish && !hist_q;

  calc_seq_divider #(.W(W)) u_div (
    .IN_clk      (IN_clk),
    .IN_reset    (IN_reset),
    .start_i     (start && (IN_ALU_OP == OP_DIV || IN_ALU_OP == OP_MOD)),
    .dividend_i  ({IN_SRCH, IN_SRCL}),
    .divisor_i   ({IN_DSTH, IN_DSTL}),
    .done_o      (div_done),
    .dbz_o       (div_dbz),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    digit     = b_q[cnt_q * MUL_DIGIT +: MUL_DIGIT];
    prod_next = acc_q + (({{W{1'b0}}, a_q} * {{(2*W-MUL_DIGIT){1'b0}}, digit})
                         << (cnt_q * MUL_DIGIT));
  end

  always_comb begin
    state_d = state_q;
    hist_d  = IN_finish;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ans_d   = ans_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    fin     = 1'b0;
    fin_ans = '0;
    fin_err = 1'b0;
    fin_ovf = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = {IN_SRCH, IN_SRCL};
          b_d     = {IN_DSTH, IN_DSTL};
          op_d    = IN_ALU_OP;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        case (op_q)
          OP_ADD: begin
            fin     = 1'b1;
            fin_ans = sum[W-1:0];
            fin_ovf = sum[W];
          end
          OP_SUB: begin
            fin     = 1'b1;
            fin_ans = a_q - b_q;
            fin_ovf = (a_q < b_q);
          end
          OP_MUL: begin
            acc_d = prod_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(NDIG - 1)) begin
              fin     = 1'b1;
              fin_ans = prod_next[W-1:0];
              fin_ovf = (prod_next[2*W-1:W] != '0);
            end
          end
          OP_DIV, OP_MOD: begin
            if (div_done) begin
              fin     = 1'b1;
              fin_err = div_dbz;
              if (div_dbz)             fin_ans = '1;
              else if (op_q == OP_DIV) fin_ans = div_quo;
              else                     fin_ans = div_rem;
            end
          end
          default: begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end
        endcase
        if (fin) begin
          ans_d   = fin_ans;
          err_d   = fin_err;
          ovf_d   = fin_ovf;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge IN_clk or negedge IN_reset) begin
    if (!IN_reset) begin
      state_q <= ST_IDLE;
      hist_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ans_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ans_q   <= ans_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign OUT_ans   = ans_q;
  assign OUT_done  = done_q;
  assign OUT_busy  = busy_q;
  assign OUT_err   = err_q;
  assign OUT_ovf   = ovf_q;
  assign OUT_state = state_q;

endmodule

// File: tb/tb_calc_alu_responder.sv
// Scoreboard bench for calc_alu_responder: expected results are queued at
// each request and compared when OUT_done pulses.
`timescale 1ns/1ps
module tb_calc_alu_responder;
  import calc_pkg::*;

  logic        IN_clk = 1'b0;
  logic        IN_reset = 1'b0;
  logic [7:0]  IN_SRCH = '0, IN_SRCL = '0, IN_DSTH = '0, IN_DSTL = '0;
  logic [3:0]  IN_ALU_OP = '0;
  logic        IN_finish = 1'b0;
  logic [15:0] OUT_ans;
  logic        OUT_done, OUT_busy, OUT_err, OUT_ovf;
  logic [1:0]  OUT_state;

  calc_alu_responder dut (
    .IN_clk    (IN_clk),
    .IN_reset  (IN_reset),
    .IN_SRCH   (IN_SRCH),
    .IN_SRCL   (IN_SRCL),
    .IN_DSTH   (IN_DSTH),
    .IN_DSTL   (IN_DSTL),
    .IN_ALU_OP (IN_ALU_OP),
    .IN_finish (IN_finish),
    .OUT_ans   (OUT_ans),
    .OUT_done  (OUT_done),
    .OUT_busy  (OUT_busy),
    .OUT_err   (OUT_err),
    .OUT_ovf   (OUT_ovf),
    .OUT_state (OUT_state)
  );

  always #5 IN_clk = ~IN_clk;

  typedef struct {
    logic [15:0] ans;
    logic        err;
    logic        ovf;
    int          n;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    exp_t e;
    logic [16:0] s;
    logic [31:0] p;
    e.ans = '0; e.err = 1'b0; e.ovf = 1'b0; e.n = 1;
    case (op)
      4'hA: begin s = {1'b0, a} + {1'b0, b}; e.ans = s[15:0]; e.ovf = s[16]; end
      4'hB: begin e.ans = a - b; e.ovf = (a < b); end
      4'hC: begin p = 32'(a) * 32'(b); e.ans = p[15:0]; e.ovf = (p[31:16] != 0); e.n = 4; end
      4'hD, 4'hE: begin
        if (b == 0) begin e.ans = 16'hFFFF; e.err = 1'b1; end
        else begin e.ans = (op == 4'hD) ? a / b : a % b; e.n = 16; end
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Issue one request; optionally raise a second IN_finish edge at k+reedge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input int reedge);
    exp_t e;
    bit got;
    int pulses;
    @(negedge IN_clk);
    {IN_SRCH, IN_SRCL} = a;
    {IN_DSTH, IN_DSTL} = b;
    IN_ALU_OP = op;
    IN_finish = 1'b1;
    sb.push_back(model(a, b, op));
    @(posedge IN_clk); #1;
    check("busy_at_k", OUT_busy, 1);
    check("state_calc", OUT_state, 1);
    IN_finish = 1'b0;
    {IN_SRCH, IN_SRCL, IN_DSTH, IN_DSTL} = $urandom;
    IN_ALU_OP = 4'($urandom);
    got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      if (reedge != 0 && c == reedge) IN_finish = 1'b1;
      if (reedge != 0 && c == reedge + 2) IN_finish = 1'b0;
      @(posedge IN_clk); #1;
      if (OUT_done) begin
        got = 1'b1;
        e = sb.pop_front();
        check("ans", OUT_ans, e.ans);
        check("err", OUT_err, e.err);
        check("ovf", OUT_ovf, e.ovf);
        check("latency", c, e.n);
        check("busy_done", OUT_busy, 0);
        check("state_done", OUT_state, 2);
        $display("op=%h a=%0d b=%0d ans=%h err=%b ovf=%b cycles=%0d",
                 op, a, b, OUT_ans, OUT_err, OUT_ovf, c);
      end else if (!OUT_busy) begin
        check("busy_calc", OUT_busy, 1);
      end
    end
    if (!got) begin
      check("done_timeout", 0, 1);
      e = sb.pop_front();
    end
    IN_finish = 1'b0;
    @(posedge IN_clk); #1;
    check("done_pulse_width", OUT_done, 0);
    check("state_idle", OUT_state, 0);
    pulses = 0;
    repeat (20) begin
      @(posedge IN_clk); #1;
      if (OUT_done) pulses++;
    end
    check("no_extra_done", pulses, 0);
    check("ans_hold", OUT_ans, e.ans);
  endtask

  initial begin
    int pulses;
    int busy_seen;
    #1;
    check("rst_ans", OUT_ans, 0);
    check("rst_done", OUT_done, 0);
    check("rst_busy", OUT_busy, 0);
    check("rst_state", OUT_state, 0);
    check("prio_mod", op_priority(4'hE), 3);
    check("prio_mul", op_priority(4'hC), 2);
    check("prio_add", op_priority(4'hA), 1);
    repeat (2) @(negedge IN_clk);
    IN_reset = 1'b1;

    run_op(16'd123, 16'd45, 4'hA, 0);
    run_op(16'hFFF0, 16'h0020, 4'hA, 0);
    run_op(16'd300, 16'd500, 4'hB, 0);
    run_op(16'd999, 16'd999, 4'hC, 0);
    run_op(16'd250, 16'd200, 4'hC, 0);
    run_op(16'd999, 16'd7, 4'hD, 5);
    run_op(16'd999, 16'd7, 4'hE, 0);
    run_op(16'hFFFF, 16'h0100, 4'hD, 0);
    run_op(16'd1234, 16'd0, 4'hD, 0);
    run_op(16'd5, 16'd3, 4'h3, 0);

    // Abort a divide with reset at k+8, hold IN_finish high across release.
    @(negedge IN_clk);
    {IN_SRCH, IN_SRCL} = 16'd999;
    {IN_DSTH, IN_DSTL} = 16'd7;
    IN_ALU_OP = 4'hD;
    IN_finish = 1'b1;
    @(posedge IN_clk); #1;
    IN_finish = 1'b0;
    repeat (8) @(posedge IN_clk);
    #1;
    IN_reset = 1'b0;
    IN_finish = 1'b1;
    #1;
    check("abort_ans", OUT_ans, 0);
    check("abort_err", OUT_err, 0);
    check("abort_done", OUT_done, 0);
    check("abort_busy", OUT_busy, 0);
    check("abort_state", OUT_state, 0);
    repeat (2) @(negedge IN_clk);
    IN_reset = 1'b1;
    pulses = 0;
    busy_seen = 0;
    repeat (20) begin
      @(posedge IN_clk); #1;
      if (OUT_done) pulses++;
      if (OUT_busy) busy_seen++;
    end
    check("held_finish_done", pulses, 0);
    check("held_finish_busy", busy_seen, 0);
    @(negedge IN_clk);
    IN_finish = 1'b0;
    run_op(16'd999, 16'd7, 4'hD, 0);

    if (sb.size() != 0) check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
